bus_control_sequencer: RTL and testbench

- Microcoded control sequencer for the 8-bit computer; shares the single 8-bit bus between register sources and destinations.
- Each cycle it emits one encoded bus-source select and one encoded bus-destination select, each with an enable.
- Each select/enable pair drives a 4-to-16 one-hot address decoder, producing per-register output-enable and load strobes.
- Sequences fetch and execute T-states from the current opcode, handles halt, and counts retired instructions.

---
 rtl/bus_control_sequencer.sv | 173 +++++++++++++++++
 tb/tb_bus_control_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_control_sequencer.sv
// Microcoded bus control sequencer for the 8-bit computer.
// Each T-state issues one source->destination bus transfer (or none),
// steps fetch/execute states from the current opcode, and counts retired
// instructions. Bus controls are decoded combinationally from state, opcode and run.
module bus_control_sequencer #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [SEL_W-1:0]    src_sel,
  output logic                src_en,
  output logic [SEL_W-1:0]    dst_sel,
  output logic                dst_en,
  output logic                pc_inc,
  output logic                alu_sub,
  output logic                halted,
  output logic [2:0]          t_state,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_EXEC0  = 3'd2,
    ST_EXEC1  = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Bus source IDs
  localparam logic [SEL_W-1:0] SRC_PC  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SRC_RAM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SRC_IR  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SRC_A   = SEL_W'(3);
  localparam logic [SEL_W-1:0] SRC_ALU = SEL_W'(4);

  // Bus destination IDs
  localparam logic [SEL_W-1:0] DST_MAR = SEL_W'(0);
  localparam logic [SEL_W-1:0] DST_IR  = SEL_W'(1);
  localparam logic [SEL_W-1:0] DST_A   = SEL_W'(2);
  localparam logic [SEL_W-1:0] DST_B   = SEL_W'(3);
  localparam logic [SEL_W-1:0] DST_RAM = SEL_W'(4);
  localparam logic [SEL_W-1:0] DST_OUT = SEL_W'(5);
  localparam logic [SEL_W-1:0] DST_PC  = SEL_W'(6);

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;

  logic [SEL_W-1:0]   w_src;
  logic [SEL_W-1:0]   w_dst;
  logic               w_xfer;
  logic               w_pc_inc;
  logic               w_alu_sub;
  logic               w_last;
  logic               w_to_halt;
  logic               w_active;

  // Microcode ROM: transfer, strobes and step termination for the current T-state
  always_comb begin
    w_src     = '0;
    w_dst     = '0;
    w_xfer    = 1'b0;
    w_pc_inc  = 1'b0;
    w_alu_sub = 1'b0;
    w_last    = 1'b0;
    w_to_halt = 1'b0;
    case (r_state)
      ST_FETCH0: begin
        w_xfer = 1'b1; w_src = SRC_PC; w_dst = DST_MAR;
      end
      ST_FETCH1: begin
        w_xfer = 1'b1; w_src = SRC_RAM; w_dst = DST_IR; w_pc_inc = 1'b1;
      end
      ST_EXEC0: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_xfer = 1'b1; w_src = SRC_IR; w_dst = DST_MAR;
          end
          OP_LDI: begin
            w_xfer = 1'b1; w_src = SRC_IR; w_dst = DST_A; w_last = 1'b1;
          end
          OP_JMP: begin
            w_xfer = 1'b1; w_src = SRC_IR; w_dst = DST_PC; w_last = 1'b1;
          end
          OP_OUT: begin
            w_xfer = 1'b1; w_src = SRC_A; w_dst = DST_OUT; w_last = 1'b1;
          end
          OP_HLT:  w_to_halt = 1'b1;
          default: w_last    = 1'b1;
        endcase
      end
      ST_EXEC1: begin
        case (opcode)
          OP_LDA: begin
            w_xfer = 1'b1; w_src = SRC_RAM; w_dst = DST_A; w_last = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_xfer = 1'b1; w_src = SRC_RAM; w_dst = DST_B;
          end
          OP_STA: begin
            w_xfer = 1'b1; w_src = SRC_A; w_dst = DST_RAM; w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      ST_EXEC2: begin
        w_last = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          w_xfer    = 1'b1;
          w_src     = SRC_ALU;
          w_dst     = DST_A;
          w_alu_sub = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // Bus controls are only driven while stepping and not halted
  assign w_active = run && (r_state != ST_HALT);

  assign src_en      = w_active & w_xfer;
  assign dst_en      = w_active & w_xfer;
  assign src_sel     = (w_active && w_xfer) ? w_src : '0;
  assign dst_sel     = (w_active && w_xfer) ? w_dst : '0;
  assign pc_inc      = w_active & w_pc_inc;
  assign alu_sub     = w_active & w_alu_sub;
  assign halted      = (r_state == ST_HALT);
  assign t_state     = r_state;
  assign instr_count = r_count;

  // T-state sequencing and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH0;
      r_count <= '0;
    end else if (run) begin
      case (r_state)
        ST_FETCH0: r_state <= ST_FETCH1;
        ST_FETCH1: r_state <= ST_EXEC0;
        ST_EXEC0, ST_EXEC1, ST_EXEC2: begin
          if (w_to_halt) begin
            r_state <= ST_HALT;
            r_count <= r_count + CNT_W'(1);
          end else if (w_last) begin
            r_state <= ST_FETCH0;
            r_count <= r_count + CNT_W'(1);
          end else if (r_state == ST_EXEC0) begin
            r_state <= ST_EXEC1;
          end else begin
            r_state <= ST_EXEC2;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Randomized scoreboard bench for bus_control_sequencer.
`timescale 1ns/1ps
module tb_bus_control_sequencer;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned CNT_W    = 8;

  // Register IDs on the shared bus
  localparam int S_PC = 0, S_RAM = 1, S_IR = 2, S_A = 3, S_ALU = 4;
  localparam int D_MAR = 0, D_IR = 1, D_A = 2, D_B = 3, D_RAM = 4, D_OUT = 5, D_PC = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic [SEL_W-1:0]    src_sel;
  logic                src_en;
  logic [SEL_W-1:0]    dst_sel;
  logic                dst_en;
  logic                pc_inc;
  logic                alu_sub;
  logic                halted;
  logic [2:0]          t_state;
  logic [CNT_W-1:0]    instr_count;

  bus_control_sequencer #(.OPCODE_W(OPCODE_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .src_sel(src_sel), .src_en(src_en), .dst_sel(dst_sel), .dst_en(dst_en),
    .pc_inc(pc_inc), .alu_sub(alu_sub), .halted(halted),
    .t_state(t_state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int src;
    int dst;
    bit pc;
    bit sub;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_pass    = 0;
  int    n_total   = 0;
  int    exp_count = 0;
  bit    exp_halt  = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  function automatic void push(input int s, input int d, input bit pc, input bit sub);
    xfer_t x;
    x.src = s; x.dst = d; x.pc = pc; x.sub = sub;
    exp_q.push_back(x);
  endfunction

  // Reference model: queue the bus transfers of one instruction, return its exec length
  function automatic void model_instr(input logic [3:0] op, output int n_exec, output bit halts);
    halts = 1'b0;
    push(S_PC, D_MAR, 1'b0, 1'b0);
    push(S_RAM, D_IR, 1'b1, 1'b0);
    case (op)
      4'd1: begin push(S_IR, D_MAR, 0, 0); push(S_RAM, D_A, 0, 0); n_exec = 2; end
      4'd2, 4'd3: begin
        push(S_IR, D_MAR, 0, 0); push(S_RAM, D_B, 0, 0);
        push(S_ALU, D_A, 0, (op == 4'd3)); n_exec = 3;
      end
      4'd4:  begin push(S_IR, D_MAR, 0, 0); push(S_A, D_RAM, 0, 0); n_exec = 2; end
      4'd5:  begin push(S_IR, D_A, 0, 0);   n_exec = 1; end
      4'd6:  begin push(S_IR, D_PC, 0, 0);  n_exec = 1; end
      4'd14: begin push(S_A, D_OUT, 0, 0);  n_exec = 1; end
      4'd15: begin n_exec = 1; halts = 1'b1; end
      default: n_exec = 1;
    endcase
  endfunction

  // Monitor: every presented transfer is popped from the scoreboard
  always @(negedge clk) begin
    xfer_t x;
    if (rst_n) begin
      check("en_pair", int'(src_en), int'(dst_en));
      if (!run || exp_halt)
        check("idle_ctrl", int'({src_en, dst_en, pc_inc, alu_sub, src_sel, dst_sel}), 0);
      if (src_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", int'(src_sel), -1);
        end else begin
          x = exp_q.pop_front();
          check("src_sel", int'(src_sel), x.src);
          check("dst_sel", int'(dst_sel), x.dst);
          check("pc_inc",  int'(pc_inc),  int'(x.pc));
          check("alu_sub", int'(alu_sub), int'(x.sub));
        end
      end else begin
        check("sel_idle", int'({src_sel, dst_sel, pc_inc, alu_sub}), 0);
      end
    end
  end

  // Drive one instruction; optional forced stall and optional reset abort at step k
  task automatic do_instr(input logic [3:0] op, input int stall_pct,
                          input int stall_at, input int abort_at);
    int  n_exec;
    bit  halts;
    int  k;
    int  forced;
    model_instr(op, n_exec, halts);
    k = 0;
    forced = 0;
    while (k < 2 + n_exec) begin
      opcode = (k < 2) ? 4'($urandom) : op;
      if (k == abort_at) begin
        check("pre_abort_state", int'(t_state), k);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("async_rst_state", int'(t_state), 0);
        check("async_rst_count", int'(instr_count), 0);
        exp_q.delete();
        exp_count = 0;
        exp_halt  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if ((k == stall_at && forced < 3) || ($urandom_range(99) < stall_pct)) begin
        if (k == stall_at) forced++;
        run = 1'b0;
        check("stall_state", int'(t_state), k);
      end else begin
        run = 1'b1;
        check("t_state", int'(t_state), k);
        k++;
      end
      @(posedge clk); #1;
    end
    run = 1'b0;
    exp_count = (exp_count + 1) % 256;
    if (halts) exp_halt = 1'b1;
    check("end_state", int'(t_state), halts ? 5 : 0);
    check("instr_count", int'(instr_count), exp_count);
    check("halted", int'(halted), int'(halts));
    check("drained", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    check("rst_state", int'(t_state), 0);
    check("rst_count", int'(instr_count), 0);
    check("rst_halted", int'(halted), 0);
    exp_q.delete();
    exp_count = 0;
    exp_halt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    run    = 1'b0;
    opcode = '0;
    apply_reset();

    do_instr(4'd1,  0, -1, -1);   // LDA
    do_instr(4'd3,  0, -1, -1);   // SUB
    do_instr(4'd4,  0,  3, -1);   // STA with 3-cycle stall in EXEC1
    do_instr(4'd10, 0, -1, -1);   // undefined -> NOP
    do_instr(4'd2,  0, -1,  3);   // ADD aborted by reset in EXEC1
    do_instr(4'd2,  0, -1, -1);   // ADD after reset

    for (int i = 0; i < 200; i++)
      do_instr(4'($urandom_range(14)), 20, -1, -1);

    do_instr(4'd15, 0, -1, -1);   // HLT
    for (int i = 0; i < 20; i++) begin
      run    = 1'($urandom);
      opcode = 4'($urandom);
      @(posedge clk); #1;
      check("halt_hold_state", int'(t_state), 5);
      check("halt_hold_flag", int'(halted), 1);
      check("halt_hold_count", int'(instr_count), exp_count);
    end
    run = 1'b0;

    apply_reset();
    for (int i = 0; i < 256; i++) do_instr(4'd0, 0, -1, -1);
    check("nop_wrap", int'(instr_count), 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
